// File: rtl/hv_line_drawer_if.sv
// Command and pixel-write handshake bundle for the horizontal/vertical line drawer.
interface hv_line_drawer_if #(
  parameter int unsigned X_WIDTH     = 9,
  parameter int unsigned Y_WIDTH     = 8,
  parameter int unsigned LEN_WIDTH   = 9,
  parameter int unsigned COLOR_WIDTH = 3
);
  logic                   start;
  logic                   dir;
  logic [X_WIDTH-1:0]     x_in;
  logic [Y_WIDTH-1:0]     y_in;
  logic [LEN_WIDTH-1:0]   length;
  logic [COLOR_WIDTH-1:0] color_in;
  logic                   draw_ready;
  logic                   draw;
  logic [X_WIDTH-1:0]     x_out;
  logic [Y_WIDTH-1:0]     y_out;
  logic [COLOR_WIDTH-1:0] color_out;
  logic                   busy;
  logic                   done;

  modport master (
    output start, dir, x_in, y_in, length, color_in, draw_ready,
    input  draw, x_out, y_out, color_out, busy, done
  );

  modport slave (
    input  start, dir, x_in, y_in, length, color_in, draw_ready,
    output draw, x_out, y_out, color_out, busy, done
  );
endinterface

// File: rtl/hv_line_drawer.sv
// Draws a clipped horizontal or vertical line, one pixel per accepted draw/draw_ready cycle.
module hv_line_drawer #(
  parameter int unsigned X_WIDTH     = 9,
  parameter int unsigned Y_WIDTH     = 8,
  parameter int unsigned LEN_WIDTH   = 9,
  parameter int unsigned COLOR_WIDTH = 3,
  parameter int unsigned X_MAX       = 319,
  parameter int unsigned Y_MAX       = 239
) (
  input  logic           clk,
  input  logic           reset,
  hv_line_drawer_if.slave bus
);

  localparam logic [X_WIDTH-1:0] XM = X_WIDTH'(X_MAX);
  localparam logic [Y_WIDTH-1:0] YM = Y_WIDTH'(Y_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q;
  logic [X_WIDTH-1:0]     x_q;
  logic [Y_WIDTH-1:0]     y_q;
  logic [LEN_WIDTH-1:0]   rem_q;
  logic [COLOR_WIDTH-1:0] color_q;
  logic                   dir_q;
  logic                   draw_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   last_d;

  // Last pixel either exhausts the count or sits on the screen edge of the active axis.
  always_comb begin
    last_d = (rem_q == LEN_WIDTH'(1));
    if (dir_q) begin
      if (x_q == XM) last_d = 1'b1;
    end else begin
      if (y_q == YM) last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      rem_q   <= '0;
      color_q <= '0;
      dir_q   <= 1'b0;
      draw_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            x_q     <= bus.x_in;
            y_q     <= bus.y_in;
            dir_q   <= bus.dir;
            color_q <= bus.color_in;
            rem_q   <= bus.length;
            if (bus.length == '0 || bus.x_in > XM || bus.y_in > YM) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_DRAW;
              draw_q  <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        S_DRAW: begin
          if (bus.draw_ready) begin
            rem_q <= rem_q - LEN_WIDTH'(1);
            if (last_d) begin
              // Coordinates hold on the final pixel so the edge value never wraps.
              state_q <= S_DONE;
              draw_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (dir_q) begin
              x_q <= x_q + X_WIDTH'(1);
            end else begin
              y_q <= y_q + Y_WIDTH'(1);
            end
          end
        end
        S_DONE: begin
          if (!bus.start) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          draw_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.draw      = draw_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.x_out     = x_q;
  assign bus.y_out     = y_q;
  assign bus.color_out = color_q;

endmodule

// File: tb/tb_hv_line_drawer.sv
// Scoreboard bench for hv_line_drawer: expected pixels queued by stimulus, popped by a negedge monitor.
module tb_hv_line_drawer;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  pix_t exp_q[$];
  bit   stall_prev;
  int   prev_x;
  int   prev_y;

  hv_line_drawer_if #(
    .X_WIDTH(9), .Y_WIDTH(8), .LEN_WIDTH(9), .COLOR_WIDTH(3)
  ) bus ();

  hv_line_drawer #(
    .X_WIDTH(9), .Y_WIDTH(8), .LEN_WIDTH(9), .COLOR_WIDTH(3),
    .X_MAX(319), .Y_MAX(239)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push(input int x, input int y, input int c);
    pix_t p;
    p.x = x;
    p.y = y;
    p.c = c;
    exp_q.push_back(p);
  endtask

  // Monitor: every accepted pixel must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.draw && stall_prev) begin
        chk("stall_hold_x", int'(bus.x_out), prev_x);
        chk("stall_hold_y", int'(bus.y_out), prev_y);
      end
      stall_prev = bus.draw && !bus.draw_ready;
      prev_x     = int'(bus.x_out);
      prev_y     = int'(bus.y_out);
      if (bus.draw && bus.draw_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel: got x=%0d y=%0d, required no pixel",
                   bus.x_out, bus.y_out);
        end else begin
          pix_t p;
          p = exp_q.pop_front();
          chk("pix_x", int'(bus.x_out), p.x);
          chk("pix_y", int'(bus.y_out), p.y);
          chk("pix_color", int'(bus.color_out), p.c);
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Issues one start, optionally toggles draw_ready 1,0,1,..., and checks cycles to done.
  task automatic do_line(input string name, input int x, input int y, input int len,
                         input int d, input int col, input bit toggle, input int exp_cyc);
    int cycles;
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.x_in       = 9'(x);
    bus.y_in       = 8'(y);
    bus.length     = 9'(len);
    bus.dir        = d[0];
    bus.color_in   = 3'(col);
    bus.draw_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.x_in  = '1;
    bus.y_in  = '1;
    chk({name, "_draw_rise"}, int'(bus.draw), (exp_cyc > 0) ? 1 : 0);
    cycles = 0;
    while (!bus.done && cycles < 100) begin
      bus.draw_ready = toggle ? ((cycles % 2) == 0) : 1'b1;
      @(posedge clk); #1;
      cycles++;
    end
    bus.draw_ready = 1'b1;
    chk({name, "_done"}, int'(bus.done), 1);
    chk({name, "_cycles"}, cycles, exp_cyc);
    chk({name, "_draw_low"}, int'(bus.draw), 0);
    chk({name, "_busy_low"}, int'(bus.busy), 0);
    chk({name, "_pixels_left"}, exp_q.size(), 0);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    stall_prev     = 1'b0;
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.dir        = 1'b0;
    bus.x_in       = '0;
    bus.y_in       = '0;
    bus.length     = '0;
    bus.color_in   = '0;
    bus.draw_ready = 1'b1;

    #12;
    chk("rst_draw", int'(bus.draw), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_x", int'(bus.x_out), 0);
    chk("rst_y", int'(bus.y_out), 0);
    chk("rst_color", int'(bus.color_out), 0);
    @(posedge clk); #1;
    reset = 1'b1;

    push(10, 20, 5); push(10, 21, 5); push(10, 22, 5); push(10, 23, 5); push(10, 24, 5);
    do_line("vert", 10, 20, 5, 0, 5, 1'b0, 5);

    push(100, 50, 3); push(101, 50, 3); push(102, 50, 3); push(103, 50, 3);
    do_line("horiz_stall", 100, 50, 4, 1, 3, 1'b1, 7);

    do_line("len0", 40, 40, 0, 0, 1, 1'b0, 0);
    @(posedge clk); #1;
    chk("len0_idle", int'(bus.done), 0);

    push(317, 7, 6); push(318, 7, 6); push(319, 7, 6);
    do_line("clip_h", 317, 7, 10, 1, 6, 1'b0, 3);

    push(2, 239, 2);
    do_line("clip_v", 2, 239, 3, 0, 2, 1'b0, 1);

    do_line("offscreen", 320, 5, 4, 1, 1, 1'b0, 0);

    // Reset while the 3rd pixel of a 20-pixel line is presented.
    push(5, 30, 4); push(5, 31, 4);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.x_in = 9'd5; bus.y_in = 8'd30; bus.length = 9'd20;
    bus.dir = 1'b0; bus.color_in = 3'd4; bus.draw_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_y_before_rst", int'(bus.y_out), 32);
    reset = 1'b0;
    #1;
    chk("mid_rst_draw", int'(bus.draw), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_x", int'(bus.x_out), 0);
    chk("mid_rst_y", int'(bus.y_out), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_draw", int'(bus.draw), 0);
    chk("post_rst_done", int'(bus.done), 0);
    chk("post_rst_pixels_left", exp_q.size(), 0);
    push(50, 60, 7); push(50, 61, 7); push(50, 62, 7);
    do_line("after_rst", 50, 60, 3, 0, 7, 1'b0, 3);

    // start held high through DONE must not redraw.
    push(200, 100, 1); push(201, 100, 1);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.x_in = 9'd200; bus.y_in = 8'd100; bus.length = 9'd2;
    bus.dir = 1'b1; bus.color_in = 3'd1; bus.draw_ready = 1'b1;
    @(posedge clk); #1;
    chk("held_draw_rise", int'(bus.draw), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("held_done", int'(bus.done), 1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("held_done_stays", int'(bus.done), 1);
    chk("held_no_redraw", int'(bus.draw), 0);
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("held_back_idle", int'(bus.done), 0);
    push(0, 0, 3);
    bus.start = 1'b1; bus.x_in = 9'd0; bus.y_in = 8'd0; bus.length = 9'd1;
    bus.dir = 1'b0; bus.color_in = 3'd3;
    @(posedge clk); #1;
    chk("restart_draw_rise", int'(bus.draw), 1);
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("restart_done", int'(bus.done), 1);
    @(posedge clk); #1;
    chk("final_pixels_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hv_line_drawer.md
Name: hv_line_drawer

Overview:
Parametrised successor to the vertical line drawer. Draws a horizontal or vertical line of programmable length from a start coordinate, one pixel per accepted cycle. Pixel writes use a draw/draw_ready handshake, so the frame-buffer or VGA write path can stall the drawer. Lines are clipped at the screen edge, and a colour value is passed through with each pixel. Sits between the shape-command FSM and the pixel-write arbiter in the lab VGA datapath.

Parameters:
X_WIDTH, 9, width of x coordinates
Y_WIDTH, 8, width of y coordinates
LEN_WIDTH, 9, width of length input (must cover max(X_MAX, Y_MAX)+1)
COLOR_WIDTH, 3, width of pixel colour
X_MAX, 319, last valid x column (inclusive)
Y_MAX, 239, last valid y row (inclusive)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  level request; sampled only in IDLE
dir  in  1  0 = vertical (y increments), 1 = horizontal (x increments)
x_in  in  X_WIDTH  start column
y_in  in  Y_WIDTH  start row
length  in  LEN_WIDTH  pixel count requested
color_in  in  COLOR_WIDTH  pixel colour
draw_ready  in  1  downstream accepts pixel this cycle
draw  out  1  pixel valid
x_out  out  X_WIDTH  current pixel column
y_out  out  Y_WIDTH  current pixel row
color_out  out  COLOR_WIDTH  latched colour
busy  out  1  high in DRAW
done  out  1  high in DONE

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE. All registers cleared: cur_x, cur_y, remaining count, color reg, dir reg = 0. Outputs draw=0, done=0, busy=0, x_out=0, y_out=0, color_out=0. Reset asserted mid-line aborts immediately. No pixel is issued after reset until a new start is sampled in IDLE.
- States: IDLE, DRAW, DONE (2-bit encoding; illegal encodings recover to IDLE).
- IDLE, start==1 at a clock edge:
  - Latch x_in, y_in, dir, color_in.
  - Load remaining = length.
  - If length==0 or the start coordinate is off-screen (x_in>X_MAX or y_in>Y_MAX), go to DONE with no pixels drawn.
  - Otherwise go to DRAW.
- DRAW:
  - draw=1, busy=1.
  - x_out/y_out/color_out driven directly from the latched registers (registered outputs, no combinational path from inputs).
  - A pixel is accepted on any edge with draw & draw_ready.
  - On acceptance: remaining decrements and the active axis increments by 1. The other axis is held.
  - draw_ready==0 stalls the drawer; x_out/y_out are held stable and remain valid.
- Termination: the accepted pixel is the last when remaining==1, or when the active-axis coordinate equals X_MAX (horizontal) or Y_MAX (vertical). Clip: no wrap-around, no off-screen pixel is ever emitted. Next state is DONE.
- DONE:
  - done=1, draw=0, busy=0.
  - Remain in DONE while start==1; return to IDLE when start==0.
  - start is not re-sampled until back in IDLE.
- Latency: with draw_ready held 1, draw rises the cycle after start is sampled. N on-screen pixels occupy N consecutive cycles, and done rises the cycle after the last acceptance.
- Input changes: x_in/y_in/length/dir/color_in may change freely during DRAW and DONE with no effect.
- Simultaneous events: reset takes priority over everything. Acceptance of the last pixel and clip on the same pixel both lead to DONE (single transition).
- Arithmetic: coordinate increments are X_WIDTH/Y_WIDTH wide. The clip compare happens before increment, so overflow never occurs.

Test Plan:
- Vertical line, x_in=10, y_in=20, length=5, dir=0, draw_ready=1 -> draw high 5 consecutive cycles; y_out=20,21,22,23,24; x_out=10 throughout; done=1 the following cycle.
- Horizontal line, x_in=100, y_in=50, length=4, dir=1, draw_ready toggling 1,0,1,0,... -> exactly 4 accepted pixels with x_out=100..103 and y_out=50; outputs held during stall cycles; done after the 4th acceptance.
- length=0 with start -> no draw pulse; done=1 one cycle after start is sampled; return to IDLE on start low.
- Clip: horizontal line, x_in=317, length=10 -> pixels x=317,318,319 only, then done. Vertical line, y_in=239, length=3 -> single pixel at y=239, then done.
- Reset pulse (reset=0) during the 3rd pixel of a 20-pixel line -> draw, busy, x_out, y_out go to 0 immediately; state IDLE; a new start after release draws the new line correctly.
- start held high through DONE -> done stays 1 with no redraw. Drop start, then reassert -> a new line begins, with draw rising one cycle after start is sampled.
